// File: rtl/regfile_alu_pkg.sv
// Shared encodings for the register file / ALU pipeline and its ALU.
package regfile_alu_pkg;

    // ALU operation encodings
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Write-source select encodings
    localparam logic SEL_DIN = 1'b0;
    localparam logic SEL_ALU = 1'b1;

endpackage : regfile_alu_pkg

// File: rtl/regfile_alu_pipe_alu.sv
// Purely combinational ALU: ADD/SUB with carry-out, AND/OR with carry forced low.
module alu_param
    import regfile_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             c
);

    // One extra bit so the carry of ADD/SUB falls out of the sum naturally.
    logic [WIDTH:0] w_sum;

    // Select the operation; SUB is a + ~b + 1 so carry=1 means no borrow.
    always_comb begin
        w_sum = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD:  w_sum = {1'b0, a} + {1'b0, b};
            OP_SUB:  w_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:  w_sum = {1'b0, a & b};
            OP_OR:   w_sum = {1'b0, a | b};
            default: w_sum = {1'b0, a | b};
        endcase
    end

    assign r = w_sum[WIDTH-1:0];
    assign c = w_sum[WIDTH];

endmodule : alu_param

// File: rtl/regfile_alu_pipe.sv
// Register file with integrated ALU, one write-back stage, forwarding from
// that stage to both read ports, and registered carry/zero flags.
module regfile_alu_pipe
    import regfile_alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             sel,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic             cout,
    output logic             zero,
    output logic             wb_valid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wb_valid;
    logic [AW-1:0]    r_wb_addr;
    logic [WIDTH-1:0] r_wb_data;
    logic             r_cout;
    logic             r_zero;

    logic [WIDTH-1:0] w_alu_r;
    logic             w_alu_c;
    logic [WIDTH-1:0] w_wb_next;

    alu_param #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op (op),
        .a  (d_out_a),
        .b  (d_out_b),
        .r  (w_alu_r),
        .c  (w_alu_c)
    );

    // Data entering the write-back stage: external data or ALU result.
    always_comb begin
        w_wb_next = d_in;
        if (sel == SEL_ALU) begin
            w_wb_next = w_alu_r;
        end else begin
            w_wb_next = d_in;
        end
    end

    // Commit the write-back stage into the array; the array is only ever
    // written from the stage, never directly from the issue inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (r_wb_valid) begin
            r_mem[r_wb_addr] <= r_wb_data;
        end
    end

    // Write-back stage: loads every issue; an idle cycle empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= {AW{1'b0}};
            r_wb_data  <= {WIDTH{1'b0}};
        end else begin
            r_wb_valid <= wr;
            if (wr) begin
                r_wb_addr <= wr_addr;
                r_wb_data <= w_wb_next;
            end
        end
    end

    // Flags only follow ALU-sourced writes; everything else holds them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cout <= 1'b0;
            r_zero <= 1'b0;
        end else if (wr && (sel == SEL_ALU)) begin
            r_cout <= w_alu_c;
            r_zero <= (w_alu_r == {WIDTH{1'b0}});
        end
    end

    // Read ports: the pending write-back entry wins over the array contents.
    always_comb begin
        d_out_a = r_mem[rd_addr_a];
        d_out_b = r_mem[rd_addr_b];
        if (r_wb_valid && (r_wb_addr == rd_addr_a)) begin
            d_out_a = r_wb_data;
        end else begin
            d_out_a = r_mem[rd_addr_a];
        end
        if (r_wb_valid && (r_wb_addr == rd_addr_b)) begin
            d_out_b = r_wb_data;
        end else begin
            d_out_b = r_mem[rd_addr_b];
        end
    end

    assign cout     = r_cout;
    assign zero     = r_zero;
    assign wb_valid = r_wb_valid;

endmodule : regfile_alu_pipe

// File: tb/tb_regfile_alu_pipe.sv
// Directed bench for regfile_alu_pipe: a 16x8 instance and an 8x4 instance.
// Expected values are queued when stimulus is driven and popped on check.
module tb_regfile_alu_pipe;
    import regfile_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit, 8-entry instance
    logic        reset, wr, sel;
    logic [1:0]  op;
    logic [2:0]  ra, rb, wa;
    logic [15:0] din, d_out_a, d_out_b;
    logic        cout, zero, wb_valid;

    // 8-bit, 4-entry instance
    logic        reset8, wr8, sel8;
    logic [1:0]  op8;
    logic [1:0]  ra8, rb8, wa8;
    logic [7:0]  din8, d_out_a8, d_out_b8;
    logic        cout8, zero8, wb_valid8;

    regfile_alu_pipe #(.WIDTH(16), .DEPTH(8)) u_dut (
        .clk(clk), .reset(reset), .wr(wr), .sel(sel), .op(op),
        .rd_addr_a(ra), .rd_addr_b(rb), .wr_addr(wa), .d_in(din),
        .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout), .zero(zero),
        .wb_valid(wb_valid)
    );

    regfile_alu_pipe #(.WIDTH(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .reset(reset8), .wr(wr8), .sel(sel8), .op(op8),
        .rd_addr_a(ra8), .rd_addr_b(rb8), .wr_addr(wa8), .d_in(din8),
        .d_out_a(d_out_a8), .d_out_b(d_out_b8), .cout(cout8), .zero(zero8),
        .wb_valid(wb_valid8)
    );

    logic [15:0] exp_q [$];
    string       tag_q [$];
    int          vectors = 0;
    int          fails   = 0;

    task automatic push(input string tag, input logic [15:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [15:0] obs);
        logic [15:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr = 1'b0; sel = SEL_DIN; op = OP_ADD;
        ra = 3'd0; rb = 3'd0; wa = 3'd0; din = 16'h0000;
        reset8 = 1'b1; wr8 = 1'b0; sel8 = SEL_DIN; op8 = OP_ADD;
        ra8 = 2'd0; rb8 = 2'd0; wa8 = 2'd0; din8 = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        reset8 = 1'b0;

        // Reset state on every address, both ports
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i);
            rb = 3'(7 - i);
            #1;
            push("rst_a", 16'h0000); chk(d_out_a);
            push("rst_b", 16'h0000); chk(d_out_b);
        end
        push("rst_cout", 16'h0000); chk({15'd0, cout});
        push("rst_zero", 16'h0000); chk({15'd0, zero});
        push("rst_wbv",  16'h0000); chk({15'd0, wb_valid});

        // Write r3 <= 1234: forwarded next cycle, then from the array
        wr = 1'b1; sel = SEL_DIN; wa = 3'd3; din = 16'h1234; ra = 3'd3;
        push("r3_fwd", 16'h1234);
        push("wbv_busy", 16'h0001);
        tick();
        wr = 1'b0;
        chk(d_out_a);
        chk({15'd0, wb_valid});
        push("r3_array", 16'h1234);
        push("wbv_idle", 16'h0000);
        tick();
        chk(d_out_a);
        chk({15'd0, wb_valid});

        // r1 <= FFFF, r2 <= 0001, then r4 <= r1 + r2 (wraps to 0, carry)
        wr = 1'b1; sel = SEL_DIN; wa = 3'd1; din = 16'hFFFF;
        tick();
        wa = 3'd2; din = 16'h0001;
        tick();
        sel = SEL_ALU; op = OP_ADD; ra = 3'd1; rb = 3'd2; wa = 3'd4;
        push("r4_add", 16'h0000);
        push("add_cout", 16'h0001);
        push("add_zero", 16'h0001);
        tick();
        wr = 1'b0; ra = 3'd4; #1;
        chk(d_out_a); chk({15'd0, cout}); chk({15'd0, zero});

        // r5 <= r2 - r1 = 0002 with borrow (cout=0)
        wr = 1'b1; sel = SEL_ALU; op = OP_SUB; ra = 3'd2; rb = 3'd1; wa = 3'd5;
        push("r5_sub", 16'h0002);
        push("sub_cout", 16'h0000);
        push("sub_zero", 16'h0000);
        tick();
        wr = 1'b0; ra = 3'd5; #1;
        chk(d_out_a); chk({15'd0, cout}); chk({15'd0, zero});

        // Back-to-back chain: r1 <= 0, r6 <= r1 + r2, r7 <= r6 - r2
        wr = 1'b1; sel = SEL_DIN; wa = 3'd1; din = 16'h0000;
        tick();
        sel = SEL_ALU; op = OP_ADD; ra = 3'd1; rb = 3'd2; wa = 3'd6;
        push("b2b_add_cout", 16'h0000);
        push("b2b_add_zero", 16'h0000);
        tick();
        chk({15'd0, cout}); chk({15'd0, zero});
        op = OP_SUB; ra = 3'd6; rb = 3'd2; wa = 3'd7;
        push("r7_sub", 16'h0000);
        push("r6_add", 16'h0001);
        push("b2b_sub_cout", 16'h0001);
        push("b2b_sub_zero", 16'h0001);
        tick();
        wr = 1'b0; ra = 3'd7; rb = 3'd6; #1;
        chk(d_out_a); chk(d_out_b); chk({15'd0, cout}); chk({15'd0, zero});

        // Same destination twice; d_in writes leave the flags alone
        wr = 1'b1; sel = SEL_DIN; wa = 3'd0; din = 16'hAAAA;
        tick();
        din = 16'h5555;
        tick();
        wr = 1'b0; ra = 3'd0; rb = 3'd0;
        push("r0_a", 16'h5555);
        push("r0_b", 16'h5555);
        push("hold_cout", 16'h0001);
        push("hold_zero", 16'h0001);
        tick();
        chk(d_out_a); chk(d_out_b); chk({15'd0, cout}); chk({15'd0, zero});

        // AND clears carry: r3 <= r0 & r6 = 5555 & 0001
        wr = 1'b1; sel = SEL_ALU; op = OP_AND; ra = 3'd0; rb = 3'd6; wa = 3'd3;
        push("r3_and", 16'h0001);
        push("and_cout", 16'h0000);
        push("and_zero", 16'h0000);
        tick();
        wr = 1'b0; ra = 3'd3; #1;
        chk(d_out_a); chk({15'd0, cout}); chk({15'd0, zero});

        // Reset with r2 <= BEEF pending and another issue in the reset cycle
        wr = 1'b1; sel = SEL_DIN; wa = 3'd2; din = 16'hBEEF;
        push("pend_wbv", 16'h0001);
        tick();
        chk({15'd0, wb_valid});
        reset = 1'b1; wa = 3'd5; din = 16'h1111;
        tick();
        reset = 1'b0; wr = 1'b0; ra = 3'd2; rb = 3'd5; #1;
        push("rst_r2", 16'h0000);
        push("rst_r5", 16'h0000);
        push("rst2_wbv", 16'h0000);
        push("rst2_cout", 16'h0000);
        push("rst2_zero", 16'h0000);
        chk(d_out_a); chk(d_out_b); chk({15'd0, wb_valid});
        chk({15'd0, cout}); chk({15'd0, zero});
        push("rst_r2_later", 16'h0000);
        tick();
        chk(d_out_a);

        // 8-bit instance: FF + 01 -> 00 with carry and zero
        wr8 = 1'b1; sel8 = SEL_DIN; wa8 = 2'd3; din8 = 8'hFF;
        tick();
        wa8 = 2'd1; din8 = 8'h01;
        tick();
        sel8 = SEL_ALU; op8 = OP_ADD; ra8 = 2'd3; rb8 = 2'd1; wa8 = 2'd2;
        push("w8_add_r", 16'h0000);
        push("w8_add_cout", 16'h0001);
        push("w8_add_zero", 16'h0001);
        tick();
        wr8 = 1'b0; ra8 = 2'd2; #1;
        chk({8'h00, d_out_a8}); chk({15'd0, cout8}); chk({15'd0, zero8});

        // 8-bit instance: distinct value in every address, no aliasing
        for (int i = 0; i < 4; i++) begin
            wr8 = 1'b1; sel8 = SEL_DIN; wa8 = 2'(i); din8 = 8'(8'hA0 + i);
            tick();
        end
        wr8 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            ra8 = 2'(i);
            rb8 = 2'(3 - i);
            #1;
            push("w8_rd_a", {8'h00, 8'(8'hA0 + i)});
            push("w8_rd_b", {8'h00, 8'(8'hA3 - i)});
            chk({8'h00, d_out_a8});
            chk({8'h00, d_out_b8});
        end
        push("w8_hold_cout", 16'h0001); chk({15'd0, cout8});
        push("w8_hold_zero", 16'h0001); chk({15'd0, zero8});
        push("w8_wbv", 16'h0000);       chk({15'd0, wb_valid8});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_regfile_alu_pipe
